// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared types and constants for the Pong sequencing controller.
//   - pong_state_t : game state machine encoding
//   - SCORE_W      : width of each player's score
//   - SERVE_LEFT / SERVE_RIGHT : serve direction encodings
//   - sat_inc()    : saturating score increment
// -----------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } pong_state_t;

  localparam int SCORE_W = 4;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  // Scores stop at all-ones instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_move_divider.sv
// -----------------------------------------------------------------------------
// pong_move_divider
//   Divides qualified frame ticks down to ball-move strobes. The move period
//   starts at FRAMES_PER_MOVE. With PONG_SPEEDUP_EN defined, every 4th
//   paddle-hit tick shortens the period by one frame (never below 1).
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle frame pulse
//   en         : tick qualifier (in play, not paused, no miss this tick)
//   clear      : restart the divider and reload period / rally counter
//   hit        : a paddle overlaps the ball on this tick
//   move       : registered one-cycle move strobe
//
// Configuration macro: PONG_SPEEDUP_EN
// -----------------------------------------------------------------------------
module pong_move_divider
  import pong_pkg::*;
#(
  parameter int FRAMES_PER_MOVE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  input  logic clear,
  input  logic hit,
  output logic move
);

  localparam int P_W = (FRAMES_PER_MOVE < 2) ? 1 : $clog2(FRAMES_PER_MOVE + 1);
  localparam logic [P_W-1:0] BASE = P_W'(FRAMES_PER_MOVE);
  localparam logic [P_W-1:0] ONE  = P_W'(1);

  logic [P_W-1:0] div_q;
  logic [P_W-1:0] period;
  logic           step;

  assign step = tick && en;

  // '>=' rather than '==' so a period that shrinks below the current divider
  // value still fires on the next tick instead of running past it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      move  <= 1'b0;
    end else begin
      move <= 1'b0;
      if (clear) begin
        div_q <= '0;
      end else if (step) begin
        if (div_q >= period - ONE) begin
          move  <= 1'b1;
          div_q <= '0;
        end else begin
          div_q <= div_q + ONE;
        end
      end
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [1:0]     rally_q;
  logic [P_W-1:0] period_q;

  assign period = period_q;

  // The divider compares against the pre-edge period, so a speed-up takes
  // effect from the tick after the 4th hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rally_q  <= 2'd0;
      period_q <= BASE;
    end else if (clear) begin
      rally_q  <= 2'd0;
      period_q <= BASE;
    end else if (step && hit) begin
      rally_q <= rally_q + 2'd1;
      if (rally_q == 2'd3 && period_q > ONE) begin
        period_q <= period_q - ONE;
      end
    end
  end
`else
  logic unused_hit;

  assign period     = BASE;
  assign unused_hit = hit;
`endif

endmodule

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Game sequencer for the Pong ball datapath: IDLE -> SERVE -> PLAY ->
//   POINT -> (SERVE | OVER). Detects wall misses, keeps both scores, counts
//   the serve delay and issues registered move / recentre strobes.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   frame_tick                 : one-cycle pulse per video frame
//   start                      : synchronised start button level
//   pause                      : freezes SERVE and PLAY
//   ball_left, ball_right      : signed ball edge x coordinates
//   hit_left/right_paddle      : paddle overlap flags, used on frame_tick
//   ball_move                  : one-cycle move strobe
//   ball_reset                 : one-cycle recentre strobe
//   serve_dir                  : 0 = serve left, 1 = serve right
//   score_left, score_right    : player scores
//   game_over                  : high while in OVER
//
// Configuration macro: PONG_SPEEDUP_EN (handled in pong_move_divider)
// -----------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int X_W             = 11,
  parameter int WIDTH           = 640,
  parameter int FRAMES_PER_MOVE = 2,
  parameter int SERVE_DELAY     = 60,
  parameter int WIN_SCORE       = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic signed [X_W-1:0] ball_left,
  input  logic signed [X_W-1:0] ball_right,
  input  logic                  hit_left_paddle,
  input  logic                  hit_right_paddle,
  output logic                  ball_move,
  output logic                  ball_reset,
  output logic                  serve_dir,
  output logic [SCORE_W-1:0]    score_left,
  output logic [SCORE_W-1:0]    score_right,
  output logic                  game_over
);

  localparam int SC_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [SC_W-1:0]       SERVE_LOAD = SC_W'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0]    WIN        = SCORE_W'(WIN_SCORE);
  localparam logic signed [X_W-1:0] LEFT_WALL  = '0;
  localparam logic signed [X_W-1:0] RIGHT_WALL = X_W'(WIDTH - 1);

  pong_state_t        state_q, state_d;
  logic [SC_W-1:0]    serve_cnt_q, serve_cnt_d;
  logic [SCORE_W-1:0] score_left_d, score_right_d;
  logic               serve_dir_d;
  logic               ball_reset_d;
  logic               game_over_d;
  logic               start_q;
  logic               start_rise;
  logic               active_tick;
  logic               left_miss;
  logic               right_miss;
  logic               div_en;
  logic               div_clear;

  assign start_rise  = start && !start_q;
  assign active_tick = frame_tick && !pause;

  // Left miss wins when both walls would register on the same tick.
  assign left_miss  = (ball_left <= LEFT_WALL) && !hit_left_paddle;
  assign right_miss = !left_miss && (ball_right >= RIGHT_WALL) && !hit_right_paddle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      serve_cnt_q <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      ball_reset  <= 1'b0;
      game_over   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      score_left  <= score_left_d;
      score_right <= score_right_d;
      serve_dir   <= serve_dir_d;
      ball_reset  <= ball_reset_d;
      game_over   <= game_over_d;
      start_q     <= start;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    serve_cnt_d   = serve_cnt_q;
    score_left_d  = score_left;
    score_right_d = score_right;
    serve_dir_d   = serve_dir;
    ball_reset_d  = 1'b0;
    div_en        = 1'b0;
    div_clear     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          score_left_d  = '0;
          score_right_d = '0;
          ball_reset_d  = 1'b1;
          serve_cnt_d   = SERVE_LOAD;
          state_d       = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (active_tick) begin
          if (serve_cnt_q == '0) begin
            state_d   = ST_PLAY;
            div_clear = 1'b1;
          end else begin
            serve_cnt_d = serve_cnt_q - SC_W'(1);
          end
        end
      end

      ST_PLAY: begin
        // Scoring ticks never reach the divider, so they cannot move the ball.
        div_en = !pause && !left_miss && !right_miss;
        if (active_tick) begin
          if (left_miss) begin
            score_right_d = sat_inc(score_right);
            serve_dir_d   = SERVE_LEFT;
            state_d       = ST_POINT;
            div_clear     = 1'b1;
          end else if (right_miss) begin
            score_left_d = sat_inc(score_left);
            serve_dir_d  = SERVE_RIGHT;
            state_d      = ST_POINT;
            div_clear    = 1'b1;
          end
        end
      end

      ST_POINT: begin
        ball_reset_d = 1'b1;
        if (score_left == WIN || score_right == WIN) begin
          state_d = ST_OVER;
        end else begin
          serve_cnt_d = SERVE_LOAD;
          state_d     = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  pong_move_divider #(
    .FRAMES_PER_MOVE(FRAMES_PER_MOVE)
  ) u_move_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (frame_tick),
    .en    (div_en),
    .clear (div_clear),
    .hit   (hit_left_paddle || hit_right_paddle),
    .move  (ball_move)
  );

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Sequencing controller for the Pong bouncing-ball datapath. Turns the per-frame video tick into registered ball-move strobes and runs the game state machine: idle, serve delay, play, point scored, game over. It detects missed balls at the side walls and keeps both scores. It sits between the video timing generator, the paddle/collision logic and the ball block, and drives the ball block's `move` and recentre inputs.

## Interface
- `X_W`, 11: signed width of ball x coordinates, matching the ball block's x ports.
- `WIDTH`, 640: playfield width in pixels.
- `FRAMES_PER_MOVE`, 2: frame ticks per ball move at base speed; must be ≥1.
- `SERVE_DELAY`, 60: frame ticks between recentre and first move.
- `WIN_SCORE`, 9: score that ends the game; must be ≤15.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start` in 1: button level, already synchronised.
- `pause` in 1: level; freezes play.
- `ball_left` in X_W signed: ball left edge.
- `ball_right` in X_W signed: ball right edge.
- `hit_left_paddle` in 1: ball overlaps left paddle; sampled only on `frame_tick`.
- `hit_right_paddle` in 1: ball overlaps right paddle; sampled only on `frame_tick`.
- `ball_move` out 1: one-cycle move strobe to the ball block.
- `ball_reset` out 1: one-cycle recentre strobe.
- `serve_dir` out 1: 0 = serve toward left, 1 = toward right.
- `score_left` out 4: left player score.
- `score_right` out 4: right player score.
- `game_over` out 1: high while in OVER.

## Operation
- Reset values: state IDLE, all outputs 0, internal counters 0.
- `start_rise` is `start` high with its previous-cycle value low, using one internal register.
- State IDLE:
  - On `start_rise`: clear scores, pulse `ball_reset`, load serve counter with SERVE_DELAY, go to SERVE.
- State SERVE:
  - On each `frame_tick` with `!pause`, decrement the serve counter.
  - When the counter is 0 on a `frame_tick`, go to PLAY and clear the frame divider.
- State PLAY, on `frame_tick` with `!pause`:
  - Left miss: `ball_left <= 0` and `!hit_left_paddle`. Increment `score_right`, set `serve_dir`=0, go to POINT.
  - Right miss: otherwise, if `ball_right >= WIDTH-1` and `!hit_right_paddle`. Increment `score_left`, set `serve_dir`=1, go to POINT.
  - The left-miss check has priority over the right-miss check.
  - With no miss: increment the divider. When it reaches the current period minus 1, pulse `ball_move` and clear the divider.
  - A tick that scores never produces `ball_move`.
- State POINT, one cycle:
  - Pulse `ball_reset`.
  - If either score equals WIN_SCORE, go to OVER.
  - Otherwise reload the serve counter and go to SERVE.
- State OVER:
  - `game_over`=1; scores are held.
  - On `start_rise`: clear scores, pulse `ball_reset`, go to SERVE.
- `pause` freezes all counters and state in SERVE and PLAY. It is ignored in IDLE, POINT and OVER.
- Frame ticks in IDLE and OVER have no effect.
- Scores saturate at 15; this is unreachable within the legal WIN_SCORE range.

## Timing
- All outputs are registered.
- `ball_move` and `ball_reset` are high for exactly one cycle, in the cycle after the causing `frame_tick` or `start_rise`.
- Score update, `serve_dir` update and the POINT entry happen in the same cycle.
- `ball_reset` appears one cycle after the score update.
- `ball_move` and `ball_reset` are never asserted together.
- First `ball_move` after a serve: (SERVE_DELAY+1)+FRAMES_PER_MOVE frame ticks after `ball_reset`.
- Reset asserted mid-play forces the reset values immediately, asynchronously. Any pending strobe is dropped.

## Configuration
- `PONG_SPEEDUP_EN` defined:
  - A 2-bit rally counter increments on each `frame_tick` in PLAY where a paddle hit flag is set.
  - On every wrap to 0 (every 4th hit), the move period decrements by 1, floor 1.
  - Period and rally counter reload (FRAMES_PER_MOVE, 0) on entry to POINT and on any reset.
- Undefined: the period is constant at FRAMES_PER_MOVE and there is no rally counter.

## Structure
- Shared package `pong_pkg`:
  - state enum `pong_state_t` (IDLE, SERVE, PLAY, POINT, OVER);
  - score width constant `SCORE_W`=4;
  - serve direction constants `SERVE_LEFT`/`SERVE_RIGHT`.
- One sub-module, `pong_move_divider`: frame divider, period register and optional speed-up logic. Its I/O is tick, enable, clear, hit, and a `move` pulse output.
- FSM, scoring and serve counter stay in the top.

## Test plan
- Reset, pulse `start`, SERVE_DELAY=3 → one `ball_reset` cycle; first `ball_move` on the cycle after frame tick 6 (3+1+2 with FRAMES_PER_MOVE=2); then every 2nd tick.
- PLAY, `ball_left`=0, `hit_left_paddle`=0 on a tick → `score_right` 0→1, `serve_dir`=0, no `ball_move` that tick, `ball_reset` one cycle later.
- `ball_left`=0 with `hit_left_paddle`=1 → no score; moves continue at the normal cadence.
- Left score reaches WIN_SCORE=2 → `game_over`=1; further ticks change nothing; `start_rise` → scores 0, `ball_reset`, SERVE.
- `pause` held for 10 ticks in PLAY → no `ball_move`, divider frozen; the release resumes the cadence where it stopped. `rst_n` low mid-PLAY → all outputs 0 within the same cycle.
- With `PONG_SPEEDUP_EN` and FRAMES_PER_MOVE=3: after 4 paddle-hit ticks → moves every 2 ticks; after 8 → every tick; after 12 → still every tick (floor 1); after a point → back to 3.
